muacm_in_arb: RTL and testbench

Two-channel packet arbiter for the USB CDC-ACM IN (device-to-host) pipe. It sits in the clk_usb domain between two byte-stream producers and the muacm core's in_* port. Producers are, for example, the CPU console crossed over by muacm_xclk and a local status/debug source. It grants the pipe round-robin at burst granularity, bounds each burst, releases idle owners, and drives the core's flush controls.

---
 rtl/muacm_in_arb.sv | 127 ++++++++++++
 tb/tb_muacm_in_arb.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muacm_in_arb.sv
// muacm_in_arb: two-channel round-robin burst arbiter feeding the muacm IN pipe.
// Optional per-grant channel tag byte (0xF0 | channel) enabled by defining ARB_CHAN_TAG_EN.
module muacm_in_arb #(
    parameter int MAX_BURST = 64,
    parameter int IDLE_REL  = 255
) (
    input  logic       clk_usb,
    input  logic       rst_usb,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    input  logic       s1_valid,
    output logic       s1_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_flush_now,
    output logic       m_flush_time,
    output logic [1:0] grant
);
    typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;

    localparam logic [7:0] MB = 8'(MAX_BURST);
    localparam logic [9:0] IR = 10'(IDLE_REL);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_gnt_q, last_gnt_d;
    logic       flush_now_q, flush_now_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [9:0] idle_cnt_q, idle_cnt_d;
`ifdef ARB_CHAN_TAG_EN
    logic [1:0] prev_owner_q, prev_owner_d;
`endif

    logic       xfer, hdr, own_valid, own_last, beat, pick;
    logic [7:0] own_data;

    assign xfer      = state_q == XFER;
    assign hdr       = state_q == HDR;
    assign own_valid = owner_q ? s1_valid : s0_valid;
    assign own_last  = owner_q ? s1_last : s0_last;
    assign own_data  = owner_q ? s1_data : s0_data;
    assign beat      = xfer & own_valid & m_ready;
    assign pick      = (s0_valid & s1_valid) ? ~last_gnt_q : s1_valid;

    assign m_flush_now  = flush_now_q;
    assign m_flush_time = ~rst_usb;

    // Route the owner (or its tag byte) to the core; nothing is driven while idle
    always_comb begin
        m_valid  = xfer ? own_valid : hdr;
        m_data   = xfer ? own_data : hdr ? (8'hF0 | {7'd0, owner_q}) : 8'h00;
        m_last   = xfer & own_last;
        s0_ready = xfer & ~owner_q & m_ready;
        s1_ready = xfer & owner_q & m_ready;
        grant    = (xfer | hdr) ? {owner_q, ~owner_q} : 2'b00;
    end

    // Arbitrate in IDLE, count beats and idle cycles in XFER, release on last/burst/idle
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        beat_cnt_d  = beat_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        flush_now_d = 1'b0;
`ifdef ARB_CHAN_TAG_EN
        prev_owner_d = prev_owner_q;
`endif
        if (state_q == IDLE) begin
            if (s0_valid | s1_valid) begin
                owner_d    = pick;
                last_gnt_d = pick;
                beat_cnt_d = 8'd0;
                idle_cnt_d = 10'd0;
`ifdef ARB_CHAN_TAG_EN
                state_d    = (prev_owner_q == {pick, ~pick}) ? XFER : HDR;
`else
                state_d    = XFER;
`endif
            end
        end else if (state_q == HDR) begin
            if (m_ready) begin
                state_d = XFER;
`ifdef ARB_CHAN_TAG_EN
                prev_owner_d = {owner_q, ~owner_q};
`endif
            end
        end else begin
            beat_cnt_d  = beat_cnt_q + {7'd0, beat};
            idle_cnt_d  = own_valid ? 10'd0 : idle_cnt_q + 10'd1;
            flush_now_d = beat & own_last;
            if ((beat & (own_last | (beat_cnt_d == MB))) | (idle_cnt_d == IR))
                state_d = IDLE;
        end
    end

    // State registers; reset leaves channel 0 as the winner of the first tie
    always_ff @(posedge clk_usb or posedge rst_usb) begin
        if (rst_usb) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_gnt_q   <= 1'b1;
            flush_now_q  <= 1'b0;
            beat_cnt_q   <= 8'd0;
            idle_cnt_q   <= 10'd0;
`ifdef ARB_CHAN_TAG_EN
            prev_owner_q <= 2'b00;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_gnt_q   <= last_gnt_d;
            flush_now_q  <= flush_now_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
`ifdef ARB_CHAN_TAG_EN
            prev_owner_q <= prev_owner_d;
`endif
        end
    end
endmodule

// File: tb/tb_muacm_in_arb.sv
// tb_muacm_in_arb: directed scenarios plus a randomized run against a behavioural arbiter model.
`timescale 1ns/1ps
module tb_muacm_in_arb;
    localparam int MB = 4;
    localparam int IR = 6;
`ifdef ARB_CHAN_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic       clk_usb = 1'b0, rst_usb = 1'b1;
    logic [7:0] s0_data = 8'h00, s1_data = 8'h00, m_data;
    logic       s0_last = 1'b0, s0_valid = 1'b0, s0_ready;
    logic       s1_last = 1'b0, s1_valid = 1'b0, s1_ready;
    logic       m_last, m_valid, m_ready = 1'b0, m_flush_now, m_flush_time;
    logic [1:0] grant;
    logic [15:0] outs;
    int checks = 0, failures = 0;

    muacm_in_arb #(.MAX_BURST(MB), .IDLE_REL(IR)) dut (
        .clk_usb(clk_usb), .rst_usb(rst_usb),
        .s0_data(s0_data), .s0_last(s0_last), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_last(s1_last), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_flush_now(m_flush_now), .m_flush_time(m_flush_time), .grant(grant)
    );

    assign outs = {m_data, m_last, m_valid, s0_ready, s1_ready, m_flush_now, m_flush_time, grant};

    always #5 clk_usb = ~clk_usb;

    logic [8:0] src0[$], src1[$];
    int start0, start1, lo_start, lo_len;
    logic [8:0] bq[$];
    int         bc[$];
    logic [1:0] gq[$];
    logic       fq[$], rq[$], pq[$];
    logic [7:0] dq[$], yq[$];

    task automatic apply_reset();
        rst_usb = 1'b1;
        {s0_valid, s1_valid, s0_last, s1_last, m_ready} = '0;
        s0_data = 8'h00;
        s1_data = 8'h00;
        src0.delete();
        src1.delete();
        start0 = 0; start1 = 0; lo_start = 0; lo_len = 0;
        repeat (2) @(posedge clk_usb);
        #1 rst_usb = 1'b0;
    endtask

    task automatic capture(input int n);
        bq.delete(); bc.delete(); gq.delete(); fq.delete();
        rq.delete(); pq.delete(); dq.delete(); yq.delete();
        for (int k = 0; k < n; k++) begin
            s0_valid = k >= start0 && src0.size() > 0;
            s0_data  = s0_valid ? src0[0][7:0] : 8'h00;
            s0_last  = s0_valid && src0[0][8];
            s1_valid = k >= start1 && src1.size() > 0;
            s1_data  = s1_valid ? src1[0][7:0] : 8'h00;
            s1_last  = s1_valid && src1[0][8];
            m_ready  = !(k >= lo_start && k < lo_start + lo_len);
            #1;
            gq.push_back(grant);
            fq.push_back(m_flush_now);
            rq.push_back(s0_ready | s1_ready);
            dq.push_back(m_data);
            pq.push_back((s0_valid && s0_ready) || (s1_valid && s1_ready));
            if (m_valid && m_ready) begin
                bq.push_back({m_last, m_data});
                bc.push_back(k);
            end
            if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) yq.push_back(m_data);
            if (s0_valid && s0_ready) void'(src0.pop_front());
            if (s1_valid && s1_ready) void'(src1.pop_front());
            @(posedge clk_usb);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_usb = 1'b1;
        {s0_valid, s1_valid, m_ready, s0_last} = 4'hF;
        s0_data = 8'h55;
        @(posedge clk_usb);
        #1;
        checks++;
        if (outs !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0000", outs);
        end
        rst_usb = 1'b0;
        #1;
        checks++;
        if (m_flush_time !== 1'b1 || grant !== 2'b00 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got flush_time=%b grant=%b valid=%b exp 1 00 0", m_flush_time, grant, m_valid);
        end
    endtask

    task automatic test_single_packet();
        logic [8:0] e[$];
        int lb, nf;
        apply_reset();
        src0 = '{9'h041, 9'h042, 9'h143};
        if (TAG) e.push_back(9'h0F0);
        e.push_back(9'h041); e.push_back(9'h042); e.push_back(9'h143);
        capture(12);
        checks++;
        if (bq.size() != e.size()) begin
            failures++;
            $display("FAIL single_beats got=%0d exp=%0d", bq.size(), e.size());
        end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= bq.size() || bq[i] !== e[i]) begin
                failures++;
                $display("FAIL single_byte%0d got=%h exp=%h", i, i < bq.size() ? bq[i] : 9'h1FF, e[i]);
            end
        end
        checks++;
        if (bc.size() == 0 || bc[0] != 1) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=1", bc.size() ? bc[0] : -1);
        end
        lb = bc.size() ? bc[$] : 0;
        nf = 0;
        foreach (fq[k]) nf += int'(fq[k]);
        checks++;
        if (nf != 1 || fq[lb + 1] !== 1'b1) begin
            failures++;
            $display("FAIL single_flush got count=%0d at_next=%b exp count=1 at_next=1", nf, fq[lb + 1]);
        end
        checks++;
        if (gq[lb + 1] !== 2'b00) begin
            failures++;
            $display("FAIL single_grant_release got=%b exp=00", gq[lb + 1]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] rg[$];
        int rb[$], gap[$], zeros, nf;
        logic [7:0] ey[$];
        bit in_run;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            src0.push_back(9'(i));
            src1.push_back(9'(8'h80 + i));
        end
        capture(22);
        in_run = 0; zeros = 0; nf = 0;
        for (int k = 0; k < gq.size(); k++) begin
            nf += int'(fq[k]);
            if (gq[k] != 2'b00) begin
                if (!in_run) begin
                    rg.push_back(gq[k]);
                    rb.push_back(0);
                    if (rg.size() > 1) gap.push_back(zeros);
                end
                in_run = 1;
                zeros = 0;
                if (pq[k]) rb[rb.size() - 1]++;
            end else begin
                in_run = 0;
                zeros++;
            end
        end
        checks++;
        if (rg.size() < 3 || rg[0] !== 2'b01 || rg[1] !== 2'b10 || rg[2] !== 2'b01) begin
            failures++;
            $display("FAIL rr_order got runs=%0d first=%b,%b,%b exp 01,10,01", rg.size(), rg[0], rg[1], rg[2]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= rb.size() || rb[i] != MB) begin
                failures++;
                $display("FAIL rr_burst%0d got=%0d exp=%0d", i, i < rb.size() ? rb[i] : -1, MB);
            end
        end
        checks++;
        if (gap.size() < 2 || gap[0] != 1 || gap[1] != 1) begin
            failures++;
            $display("FAIL rr_bubble got=%0d,%0d exp=1,1", gap[0], gap[1]);
        end
        checks++;
        if (nf != 0) begin
            failures++;
            $display("FAIL rr_flush got=%0d exp=0", nf);
        end
        for (int i = 0; i < 4; i++) ey.push_back(8'(i));
        for (int i = 0; i < 4; i++) ey.push_back(8'(8'h80 + i));
        for (int i = 4; i < 8; i++) ey.push_back(8'(i));
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= yq.size() || yq[i] !== ey[i]) begin
                failures++;
                $display("FAIL rr_data%0d got=%h exp=%h", i, i < yq.size() ? yq[i] : 8'hXX, ey[i]);
            end
        end
    endtask

    task automatic test_idle_release();
        int lb, n1, nf;
        apply_reset();
        src1 = '{9'h0A1, 9'h0A2};
        for (int i = 0; i < 6; i++) src0.push_back(9'(8'hB0 + i));
        start0 = 2;
        capture(24);
        lb = -1; n1 = 0; nf = 0;
        for (int k = 0; k < gq.size(); k++) begin
            nf += int'(fq[k]);
            if (pq[k] && gq[k] == 2'b10) begin
                lb = k;
                n1++;
            end
        end
        checks++;
        if (n1 != 2) begin
            failures++;
            $display("FAIL idle_s1_beats got=%0d exp=2", n1);
        end
        checks++;
        if (gq[lb + IR] !== 2'b10 || gq[lb + IR + 1] !== 2'b00) begin
            failures++;
            $display("FAIL idle_release got=%b,%b exp=10,00", gq[lb + IR], gq[lb + IR + 1]);
        end
        checks++;
        if (gq[lb + IR + 2] !== 2'b01) begin
            failures++;
            $display("FAIL idle_regrant got=%b exp=01", gq[lb + IR + 2]);
        end
        checks++;
        if (nf != 0) begin
            failures++;
            $display("FAIL idle_flush got=%0d exp=0", nf);
        end
    endtask

    task automatic test_backpressure();
        int nb, ng, nr, nd;
        logic [7:0] ed;
        apply_reset();
        for (int i = 0; i < 30; i++) src0.push_back(9'(i));
        lo_start = 2;
        lo_len = 20;
        ed = TAG ? 8'h00 : 8'h01;
        capture(26);
        nb = 0; ng = 0; nr = 0; nd = 0;
        for (int k = 2; k < 22; k++) begin
            nb += int'(pq[k]);
            ng += int'(gq[k] !== 2'b01);
            nr += int'(rq[k]);
            nd += int'(dq[k] !== ed);
        end
        checks++;
        if (nb != 0 || ng != 0) begin
            failures++;
            $display("FAIL bp_hold got beats=%0d grant_changes=%0d exp 0 0", nb, ng);
        end
        checks++;
        if (nr != 0) begin
            failures++;
            $display("FAIL bp_ready got=%0d exp=0", nr);
        end
        checks++;
        if (nd != 0) begin
            failures++;
            $display("FAIL bp_data got mismatching_cycles=%0d data=%h exp=%h", nd, dq[2], ed);
        end
        checks++;
        if (pq[22] !== 1'b1 || gq[22] !== 2'b01) begin
            failures++;
            $display("FAIL bp_resume got beat=%b grant=%b exp 1 01", pq[22], gq[22]);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            src0.push_back(9'(8'h10 + i));
            src1.push_back(9'(8'h20 + i));
        end
        capture(3);
        rst_usb = 1'b1;
        #1;
        checks++;
        if (outs !== 16'h0000) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0000", outs);
        end
        @(posedge clk_usb);
        #1 rst_usb = 1'b0;
        capture(4);
        checks++;
        if (gq[1] !== 2'b01) begin
            failures++;
            $display("FAIL midreset_first_grant got=%b exp=01", gq[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e[$];
        int nf;
        apply_reset();
        src0 = '{9'h011, 9'h112, 9'h013, 9'h114};
        src1 = '{9'h121};
        start1 = 8;
        if (TAG) e.push_back(9'h0F0);
        e.push_back(9'h011); e.push_back(9'h112); e.push_back(9'h013); e.push_back(9'h114);
        if (TAG) e.push_back(9'h0F1);
        e.push_back(9'h121);
        capture(16);
        checks++;
        if (bq.size() != e.size()) begin
            failures++;
            $display("FAIL b2b_beats got=%0d exp=%0d", bq.size(), e.size());
        end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= bq.size() || bq[i] !== e[i]) begin
                failures++;
                $display("FAIL b2b_byte%0d got=%h exp=%h", i, i < bq.size() ? bq[i] : 9'h1FF, e[i]);
            end
        end
        nf = 0;
        foreach (fq[k]) nf += int'(fq[k]);
        checks++;
        if (nf != 3) begin
            failures++;
            $display("FAIL b2b_flush got=%0d exp=3", nf);
        end
    endtask

    int  mo, mbeats, midle, mlg, mprev;
    bit  mhdr, mfl;

    task automatic model_reset();
        mo = -1; mbeats = 0; midle = 0; mlg = 1; mprev = -1; mhdr = 0; mfl = 0;
    endtask

    function automatic logic [15:0] model_out();
        logic v, l;
        logic [7:0] d;
        v = mo == 1 ? s1_valid : s0_valid;
        l = mo == 1 ? s1_last : s0_last;
        d = mo == 1 ? s1_data : s0_data;
        if (mo < 0) return {8'h00, 4'b0000, mfl, 1'b1, 2'b00};
        if (mhdr) return {8'hF0 | 8'(mo), 1'b0, 1'b1, 2'b00, mfl, 1'b1, 2'(1 << mo)};
        return {d, l, v, mo == 0 && m_ready, mo == 1 && m_ready, mfl, 1'b1, 2'(1 << mo)};
    endfunction

    task automatic model_next();
        bit v, l, b;
        v = mo == 1 ? s1_valid : s0_valid;
        l = mo == 1 ? s1_last : s0_last;
        if (mo < 0) begin
            mfl = 0;
            if (s0_valid || s1_valid) begin
                mo = (s0_valid && s1_valid) ? 1 - mlg : (s1_valid ? 1 : 0);
                mlg = mo;
                mbeats = 0;
                midle = 0;
                mhdr = TAG && mo != mprev;
            end
        end else if (mhdr) begin
            mfl = 0;
            if (m_ready) begin
                mhdr = 0;
                mprev = mo;
            end
        end else begin
            b = v && m_ready;
            mfl = b && l;
            mbeats += int'(b);
            midle = v ? 0 : midle + 1;
            if ((b && (l || mbeats == MB)) || midle == IR) mo = -1;
        end
    endtask

    task automatic test_random();
        int pv;
        logic [15:0] exp_o;
        apply_reset();
        model_reset();
        pv = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) pv = (c / 100) % 3 == 0 ? 10 : (c / 100) % 3 == 1 ? 50 : 95;
            s0_valid = $urandom_range(99) < pv;
            s1_valid = $urandom_range(99) < pv;
            s0_data  = 8'($urandom);
            s1_data  = 8'($urandom);
            s0_last  = $urandom_range(5) == 0;
            s1_last  = $urandom_range(5) == 0;
            m_ready  = $urandom_range(3) != 0;
            #1;
            exp_o = model_out();
            checks++;
            if (outs !== exp_o) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h exp=%h", c, outs, exp_o);
            end
            model_next();
            @(posedge clk_usb);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_idle_release();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
